// File: rtl/vga_pkg.sv
// Shared VGA timing types, the standard 640x480@60 mode and a helper that sums an axis period.
package vga_pkg;

    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } vga_timing_t;

    typedef struct packed {
        vga_timing_t h;
        vga_timing_t v;
    } vga_mode_t;

    localparam vga_mode_t VGA_640x480 = '{
        h: '{active: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48},
        v: '{active: 16'd480, fp: 16'd10, sync: 16'd2,  bp: 16'd33}
    };

    // Full period of one axis (pixels per line or lines per frame).
    function automatic int total(input vga_timing_t t);
        return int'(t.active) + int'(t.fp) + int'(t.sync) + int'(t.bp);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with decoded active-region and sync-pulse flags.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int TOTAL      = 800,
    parameter int ACTIVE     = 640,
    parameter int SYNC_START = 656,
    parameter int SYNC_LEN   = 96,
    parameter bit POL        = 1'b0,
    parameter int CW         = $clog2(TOTAL)
) (
    input  logic          clkIn,
    input  logic          rstIn,
    input  logic          stepIn,
    output logic [CW-1:0] cnt,
    output logic          wrapOut,
    output logic          activeOut,
    output logic          syncOut
);

    int cnt_i;

    // Decodes compare in 32 bits so a sync pulse ending exactly at TOTAL cannot alias.
    assign cnt_i     = int'(cnt);
    assign wrapOut   = (cnt_i == TOTAL - 1);
    assign activeOut = (cnt_i < ACTIVE);
    assign syncOut   = ((cnt_i >= SYNC_START) && (cnt_i < SYNC_START + SYNC_LEN)) ? POL : ~POL;

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            cnt <= '0;
        end else if (stepIn) begin
            cnt <= wrapOut ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_core.sv
// VGA timing core: pixel-tick divider, H/V raster counters, registered blanked RGB and syncs.
// Define VGA_TEST_PATTERN_EN to add patternSelIn and an eight-bar colour test pattern.
module vga_timing_core
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int COLOR_W  = 8,
    parameter int H_ACTIVE = int'(VGA_640x480.h.active),
    parameter int H_FP     = int'(VGA_640x480.h.fp),
    parameter int H_SYNC   = int'(VGA_640x480.h.sync),
    parameter int H_BP     = int'(VGA_640x480.h.bp),
    parameter int V_ACTIVE = int'(VGA_640x480.v.active),
    parameter int V_FP     = int'(VGA_640x480.v.fp),
    parameter int V_SYNC   = int'(VGA_640x480.v.sync),
    parameter int V_BP     = int'(VGA_640x480.v.bp),
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    localparam int H_TOTAL = total(vga_timing_t'{active: 16'(H_ACTIVE), fp: 16'(H_FP),
                                                 sync: 16'(H_SYNC), bp: 16'(H_BP)}),
    localparam int V_TOTAL = total(vga_timing_t'{active: 16'(V_ACTIVE), fp: 16'(V_FP),
                                                 sync: 16'(V_SYNC), bp: 16'(V_BP)}),
    localparam int HCW     = $clog2(H_TOTAL),
    localparam int VCW     = $clog2(V_TOTAL)
) (
    input  logic               clkIn,
    input  logic               rstIn,
    input  logic               enableIn,
    input  logic [COLOR_W-1:0] redIn,
    input  logic [COLOR_W-1:0] greenIn,
    input  logic [COLOR_W-1:0] blueIn,
`ifdef VGA_TEST_PATTERN_EN
    input  logic               patternSelIn,
`endif
    output logic [HCW-1:0]     pixelXOut,
    output logic [VCW-1:0]     pixelYOut,
    output logic               visibleOut,
    output logic               frameStartOut,
    output logic [COLOR_W-1:0] RED,
    output logic [COLOR_W-1:0] GREEN,
    output logic [COLOR_W-1:0] BLUE,
    output logic               HSync,
    output logic               VSync
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]   div_cnt;
    logic               pix_tick;
    logic               h_wrap;
    logic               v_wrap;
    logic               h_active;
    logic               v_active;
    logic               h_sync;
    logic               v_sync;
    logic               v_step;
    logic [COLOR_W-1:0] red_src;
    logic [COLOR_W-1:0] green_src;
    logic [COLOR_W-1:0] blue_src;

    assign pix_tick = enableIn && (div_cnt == DIV_LAST);
    assign v_step   = pix_tick && h_wrap;

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            div_cnt <= '0;
        end else if (enableIn) begin
            div_cnt <= pix_tick ? '0 : div_cnt + 1'b1;
        end
    end

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_LEN   (H_SYNC),
        .POL        (H_POL)
    ) u_h_counter (
        .clkIn     (clkIn),
        .rstIn     (rstIn),
        .stepIn    (pix_tick),
        .cnt       (pixelXOut),
        .wrapOut   (h_wrap),
        .activeOut (h_active),
        .syncOut   (h_sync)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_LEN   (V_SYNC),
        .POL        (V_POL)
    ) u_v_counter (
        .clkIn     (clkIn),
        .rstIn     (rstIn),
        .stepIn    (v_step),
        .cnt       (pixelYOut),
        .wrapOut   (v_wrap),
        .activeOut (v_active),
        .syncOut   (v_sync)
    );

    assign visibleOut = h_active && v_active;

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    if ((H_ACTIVE % 8) != 0) begin : g_bar_check
        $error("vga_timing_core: H_ACTIVE must be a multiple of 8 for the test pattern");
    end

    logic [2:0] bar_idx;
    assign bar_idx = 3'(32'(pixelXOut) / BAR_W);

    always_comb begin
        red_src   = redIn;
        green_src = greenIn;
        blue_src  = blueIn;
        if (patternSelIn) begin
            red_src   = {COLOR_W{bar_idx[2]}};
            green_src = {COLOR_W{bar_idx[1]}};
            blue_src  = {COLOR_W{bar_idx[0]}};
        end
    end
`else
    always_comb begin
        red_src   = redIn;
        green_src = greenIn;
        blue_src  = blueIn;
    end
`endif

    // Pins lag the published coordinate by one pixel tick; disabling blanks on the next clock.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            RED           <= '0;
            GREEN         <= '0;
            BLUE          <= '0;
            HSync         <= ~H_POL;
            VSync         <= ~V_POL;
            frameStartOut <= 1'b0;
        end else begin
            frameStartOut <= pix_tick && h_wrap && v_wrap;
            if (!enableIn) begin
                RED   <= '0;
                GREEN <= '0;
                BLUE  <= '0;
                HSync <= ~H_POL;
                VSync <= ~V_POL;
            end else if (pix_tick) begin
                RED   <= visibleOut ? red_src   : '0;
                GREEN <= visibleOut ? green_src : '0;
                BLUE  <= visibleOut ? blue_src  : '0;
                HSync <= h_sync;
                VSync <= v_sync;
            end
        end
    end

endmodule
